// File: rtl/mult_if_sel_seq_if.sv
// rtl/mult_if_sel_seq_if.sv - command, mux and result signal bundle for mult_if_sel_seq
//
// Purpose: groups the command handshake, the mux drive/return lines and the
// result handshake of the select-mux driver into one interface.
// Signals:
//   in_valid/in_ready/in_a/in_sel_base/in_count/in_late_en : command channel
//   a_out/c_out/ctrl_late/z_in                             : mux A, C, late flag, returned Z
//   out_valid/out_ready/out_data/out_len                   : result channel
// Modports:
//   master : command source / result sink / mux model (bench side)
//   slave  : the driver block itself
interface mult_if_sel_seq_if #(
   parameter int A_W       = 8,
   parameter int C_W       = 5,
   parameter int MAX_STEPS = 8,
   parameter int CNT_W     = 3
);
   logic                 in_valid;
   logic                 in_ready;
   logic [A_W-1:0]       in_a;
   logic [C_W-1:0]       in_sel_base;
   logic [CNT_W-1:0]     in_count;
   logic                 in_late_en;
   logic [A_W-1:0]       a_out;
   logic [C_W-1:0]       c_out;
   logic                 ctrl_late;
   logic                 z_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [MAX_STEPS-1:0] out_data;
   logic [CNT_W:0]       out_len;

   modport master (
      output in_valid, in_a, in_sel_base, in_count, in_late_en, z_in, out_ready,
      input  in_ready, a_out, c_out, ctrl_late, out_valid, out_data, out_len
   );

   modport slave (
      input  in_valid, in_a, in_sel_base, in_count, in_late_en, z_in, out_ready,
      output in_ready, a_out, c_out, ctrl_late, out_valid, out_data, out_len
   );
endinterface

// File: rtl/mult_if_sel_seq.sv
// rtl/mult_if_sel_seq.sv - sequencing driver and result packer for the priority select mux
//
// Purpose: accepts one command (operand, start select, step count, late flag),
// walks the mux select through N consecutive codes while holding the operand,
// samples the returned Z bit each step and hands off the packed bits.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous, active-high reset
//   sel_bus : slave side of mult_if_sel_seq_if (command, mux and result signals)
module mult_if_sel_seq #(
   parameter int A_W       = 8,
   parameter int C_W       = 5,
   parameter int MAX_STEPS = 8,
   parameter int CNT_W     = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   mult_if_sel_seq_if.slave       sel_bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [A_W-1:0]       a_q, a_d;
   logic [C_W-1:0]       c_q, c_d;
   logic                 late_q, late_d;
   logic [MAX_STEPS-1:0] data_q, data_d;
   logic [CNT_W:0]       len_q, len_d;
   logic [CNT_W-1:0]     step_q, step_d;
   logic [CNT_W:0]       n_q, n_d;     // step count N (1..MAX_STEPS)
   logic                 valid_q, valid_d;

   // Only the command-ready is combinational; everything else is registered.
   assign sel_bus.in_ready  = (state_q == IDLE) && !rst;
   assign sel_bus.a_out     = a_q;
   assign sel_bus.c_out     = c_q;
   assign sel_bus.ctrl_late = late_q;
   assign sel_bus.out_valid = valid_q;
   assign sel_bus.out_data  = data_q;
   assign sel_bus.out_len   = len_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      c_d     = c_q;
      late_d  = late_q;
      data_d  = data_q;
      len_d   = len_q;
      step_d  = step_q;
      n_d     = n_q;
      valid_d = valid_q;

      case (state_q)
         IDLE: begin
            // in_ready is high whenever we are here outside reset.
            if (sel_bus.in_valid) begin
               a_d     = sel_bus.in_a;
               c_d     = sel_bus.in_sel_base;
               late_d  = sel_bus.in_late_en;
               n_d     = {1'b0, sel_bus.in_count} + {{CNT_W{1'b0}}, 1'b1};
               step_d  = '0;
               data_d  = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            // z_in is the mux response to the c_out presented this cycle.
            data_d[step_q] = sel_bus.z_in;
            c_d            = c_q + {{(C_W-1){1'b0}}, 1'b1};
            step_d         = step_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if ({1'b0, step_q} == n_q - {{CNT_W{1'b0}}, 1'b1}) begin
               state_d = DONE;
               valid_d = 1'b1;
               len_d   = n_q;
               late_d  = 1'b0;
            end
         end

         DONE: begin
            // out_valid is always high here, so out_ready alone completes the hand-off.
            if (sel_bus.out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         c_q     <= '0;
         late_q  <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
         step_q  <= '0;
         n_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         c_q     <= c_d;
         late_q  <= late_d;
         data_q  <= data_d;
         len_q   <= len_d;
         step_q  <= step_d;
         n_q     <= n_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_mult_if_sel_seq.sv
// tb/tb_mult_if_sel_seq.sv - directed self-checking bench for mult_if_sel_seq
module tb_mult_if_sel_seq;

    logic clk;
    logic rst;
    logic z_force;
    int   n_chk;
    int   n_fail;

    mult_if_sel_seq_if #(.A_W(8), .C_W(5), .MAX_STEPS(8), .CNT_W(3)) bus ();

    mult_if_sel_seq #(.A_W(8), .C_W(5), .MAX_STEPS(8), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.z_in = z_force ? 1'b1 : ^bus.c_out;

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] a, input logic [4:0] base,
                          input logic [2:0] cnt, input logic late, input logic [7:0] exp_data,
                          input int stall);
        int         n;
        int         edges;
        logic [4:0] ec;
        logic [3:0] exp_len;
        n       = int'(cnt) + 1;
        exp_len = 4'(n);
        bus.in_valid    = 1'b1;
        bus.in_a        = a;
        bus.in_sel_base = base;
        bus.in_count    = cnt;
        bus.in_late_en  = late;
        chk({tag, " in_ready_pre"}, bus.in_ready === 1'b1, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 0;
        ec    = base;
        while (!bus.out_valid && edges < 20) begin
            chk({tag, " c_out"}, bus.c_out === ec, bus.c_out, ec);
            chk({tag, " ctrl_late_run"}, bus.ctrl_late === late, bus.ctrl_late, late);
            chk({tag, " a_out_run"}, bus.a_out === a, bus.a_out, a);
            chk({tag, " in_ready_run"}, bus.in_ready === 1'b0, bus.in_ready, 1'b0);
            ec = ec + 5'd1;
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, " latency"}, (edges + 1) == (n + 1), edges + 1, n + 1);
        chk({tag, " out_data"}, bus.out_data === exp_data, bus.out_data, exp_data);
        chk({tag, " out_len"}, bus.out_len === exp_len, bus.out_len, exp_len);
        chk({tag, " ctrl_late_done"}, bus.ctrl_late === 1'b0, bus.ctrl_late, 1'b0);
        chk({tag, " a_out_done"}, bus.a_out === a, bus.a_out, a);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, " stall_valid"}, bus.out_valid === 1'b1, bus.out_valid, 1'b1);
            chk({tag, " stall_data"}, bus.out_data === exp_data, bus.out_data, exp_data);
            chk({tag, " stall_len"}, bus.out_len === exp_len, bus.out_len, exp_len);
            chk({tag, " stall_in_ready"}, bus.in_ready === 1'b0, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        chk({tag, " in_ready_handoff"}, bus.in_ready === 1'b0, bus.in_ready, 1'b0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, " valid_after"}, bus.out_valid === 1'b0, bus.out_valid, 1'b0);
        chk({tag, " in_ready_after"}, bus.in_ready === 1'b1, bus.in_ready, 1'b1);
    endtask

    initial begin
        bit seen;
        n_chk  = 0;
        n_fail = 0;
        z_force         = 1'b0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_sel_base = '0;
        bus.in_count    = '0;
        bus.in_late_en  = 1'b0;
        bus.out_ready   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
        chk("rst out_valid", bus.out_valid === 1'b0, bus.out_valid, 1'b0);
        chk("rst out_data", bus.out_data === 8'h00, bus.out_data, 8'h00);
        chk("rst c_out", bus.c_out === 5'd0, bus.c_out, 5'd0);
        rst = 1'b0;
        #1;
        chk("rst released in_ready", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("idle out_ready valid", bus.out_valid === 1'b0, bus.out_valid, 1'b0);
        chk("idle out_ready in_ready", bus.in_ready === 1'b1, bus.in_ready, 1'b1);

        do_cmd("basic", 8'h3C, 5'd0, 3'd3, 1'b0, 8'b0000_0110, 0);
        do_cmd("wrap", 8'h81, 5'd30, 3'd3, 1'b0, 8'b0000_1010, 0);
        z_force = 1'b1;
        do_cmd("full", 8'h5A, 5'd9, 3'd7, 1'b0, 8'hFF, 4);
        z_force = 1'b0;
        do_cmd("late", 8'hA5, 5'd1, 3'd2, 1'b1, 8'b0000_0011, 0);

        bus.in_valid    = 1'b1;
        bus.in_a        = 8'h11;
        bus.in_sel_base = 5'd0;
        bus.in_count    = 3'd1;
        bus.in_late_en  = 1'b0;
        @(posedge clk); #1;
        bus.in_a        = 8'h22;
        bus.in_sel_base = 5'd7;
        bus.in_count    = 3'd0;
        bus.in_late_en  = 1'b1;
        chk("b2b in_ready_run", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
        chk("b2b c_out0", bus.c_out === 5'd0, bus.c_out, 5'd0);
        chk("b2b late0", bus.ctrl_late === 1'b0, bus.ctrl_late, 1'b0);
        @(posedge clk); #1;
        chk("b2b c_out1", bus.c_out === 5'd1, bus.c_out, 5'd1);
        chk("b2b a_out", bus.a_out === 8'h11, bus.a_out, 8'h11);
        @(posedge clk); #1;
        chk("b2b first valid", bus.out_valid === 1'b1, bus.out_valid, 1'b1);
        chk("b2b first data", bus.out_data === 8'b0000_0010, bus.out_data, 8'b0000_0010);
        chk("b2b first len", bus.out_len === 4'd2, bus.out_len, 4'd2);
        @(posedge clk); #1;
        chk("b2b still held", bus.out_data === 8'b0000_0010, bus.out_data, 8'b0000_0010);
        chk("b2b held in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("b2b idle in_ready", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
        chk("b2b idle valid", bus.out_valid === 1'b0, bus.out_valid, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b second a_out", bus.a_out === 8'h22, bus.a_out, 8'h22);
        chk("b2b second c_out", bus.c_out === 5'd7, bus.c_out, 5'd7);
        chk("b2b second late", bus.ctrl_late === 1'b1, bus.ctrl_late, 1'b1);
        @(posedge clk); #1;
        chk("b2b second valid", bus.out_valid === 1'b1, bus.out_valid, 1'b1);
        chk("b2b second data", bus.out_data === 8'b0000_0001, bus.out_data, 8'b0000_0001);
        chk("b2b second len", bus.out_len === 4'd1, bus.out_len, 4'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        bus.in_valid    = 1'b1;
        bus.in_a        = 8'hEE;
        bus.in_sel_base = 5'd4;
        bus.in_count    = 3'd7;
        bus.in_late_en  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst a_out", bus.a_out === 8'h00, bus.a_out, 8'h00);
        chk("midrst c_out", bus.c_out === 5'd0, bus.c_out, 5'd0);
        chk("midrst ctrl_late", bus.ctrl_late === 1'b0, bus.ctrl_late, 1'b0);
        chk("midrst out_data", bus.out_data === 8'h00, bus.out_data, 8'h00);
        chk("midrst out_len", bus.out_len === 4'd0, bus.out_len, 4'd0);
        chk("midrst out_valid", bus.out_valid === 1'b0, bus.out_valid, 1'b0);
        chk("midrst in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst in_ready after", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midrst no result", seen === 1'b0, seen, 1'b0);
        chk("midrst idle c_out", bus.c_out === 5'd0, bus.c_out, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
